dump_fsm: RTL

- Output-side controller of the SHAKE core and the counterpart of the input load stage.
- Drains squeezed Keccak state blocks from the PISO output buffer onto a ready/valid output stream.
- Tracks the requested output length and requests additional squeeze permutations when one rate block is not enough.
- Sits between the permutation stage (handshake via output_buffer_ready / output_buffer_ready_clr) and the external consumer.

---
 rtl/dump_fsm.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dump_fsm.sv
// Output-side drain controller for the SHAKE core: streams squeezed rate blocks
// from the PISO buffer to a ready/valid consumer and requests extra squeezes.
module dump_fsm #(
    parameter int W             = 64,
    parameter int LEN_W         = 32,
    parameter int RATE128_WORDS = 21,
    parameter int RATE256_WORDS = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] output_length,
    input  logic             mode,
    input  logic             output_buffer_ready,
    input  logic [W-1:0]     word_in,
    input  logic             ready_in,
    output logic             shift_enable,
    output logic             output_buffer_ready_clr,
    output logic             squeeze_request,
    output logic [W-1:0]     data_out,
    output logic             valid_out,
    output logic             last_out,
    output logic             busy,
    output logic             done
);

    localparam int SH_W = $clog2(W);
    localparam logic [LEN_W-1:0] W_LEN = LEN_W'(W);
    localparam logic [4:0] WORDS128 = 5'(RATE128_WORDS);
    localparam logic [4:0] WORDS256 = 5'(RATE256_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUFFER,
        DUMP
    } state_t;

    state_t           state, state_next;
    logic [LEN_W-1:0] remaining, remaining_next;
    logic [4:0]       word_cnt, word_cnt_next;
    logic             mode_r, mode_next;
    logic             done_next;
    logic             last_word;
    logic [W-1:0]     mask;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            word_cnt  <= '0;
            mode_r    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            word_cnt  <= word_cnt_next;
            mode_r    <= mode_next;
            done      <= done_next;
        end
    end

    // Final word carries only the low `remaining` bits; everything above is zeroed.
    always_comb begin
        last_word = (remaining <= W_LEN);
        if (remaining >= W_LEN)
            mask = '1;
        else
            mask = (W'(1) << remaining[SH_W-1:0]) - W'(1);
    end

    always_comb begin
        state_next              = state;
        remaining_next          = remaining;
        word_cnt_next           = word_cnt;
        mode_next               = mode_r;
        done_next               = 1'b0;
        shift_enable            = 1'b0;
        output_buffer_ready_clr = 1'b0;
        squeeze_request         = 1'b0;
        valid_out               = 1'b0;
        last_out                = 1'b0;
        data_out                = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (output_length != '0) begin
                        remaining_next = output_length;
                        mode_next      = mode;
                        state_next     = WAIT_BUFFER;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end

            WAIT_BUFFER: begin
                if (output_buffer_ready) begin
                    word_cnt_next = mode_r ? WORDS256 : WORDS128;
                    state_next    = DUMP;
                end
            end

            DUMP: begin
                valid_out = 1'b1;
                data_out  = word_in & mask;
                last_out  = last_word;
                if (ready_in) begin
                    shift_enable   = 1'b1;
                    remaining_next = (remaining > W_LEN) ? (remaining - W_LEN) : '0;
                    word_cnt_next  = (word_cnt != '0) ? (word_cnt - 5'd1) : '0;
                    // Finishing the request wins over an exhausted block: no extra squeeze.
                    if (last_word) begin
                        output_buffer_ready_clr = 1'b1;
                        done_next               = 1'b1;
                        state_next              = IDLE;
                    end else if (word_cnt == 5'd1) begin
                        output_buffer_ready_clr = 1'b1;
                        squeeze_request         = 1'b1;
                        state_next              = WAIT_BUFFER;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
